toy_bpu_ghr_ckpt: RTL and testbench

TOY_BPU_GHR_CKPT -- requirements
Module: toy_bpu_ghr_ckpt

---
 rtl/toy_bpu_ghr_ckpt_if.sv | 58 +++++
 rtl/toy_bpu_ghr_ckpt.sv | 165 ++++++++++++++++
 tb/tb_toy_bpu_ghr_ckpt.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/toy_bpu_ghr_ckpt_if.sv
// ---------------------------------------------------------------------------
// toy_bpu_ghr_ckpt_if
// Bundles the prediction, commit, redirect and flush channels of the global
// history checkpoint block together with its status outputs.
//   master : branch predictor / back end side (drives requests)
//   slave  : toy_bpu_ghr_ckpt (drives pred_rdy, pred_ckpt_id, bpu_ghr,
//            ckpt_cnt, cmt_ghr)
// ---------------------------------------------------------------------------
interface toy_bpu_ghr_ckpt_if #(
    parameter int GHR_LENGTH = 64,
    parameter int PRED_WIDTH = 2,
    parameter int CKPT_DEPTH = 16
);
    localparam int CKPT_IDX_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W      = $clog2(PRED_WIDTH + 1);

    // prediction block
    logic                  pred_vld;
    logic [CNT_W-1:0]      pred_cnt;
    logic [PRED_WIDTH-1:0] pred_hist;
    logic                  pred_rdy;
    logic [CKPT_IDX_W-1:0] pred_ckpt_id;
    logic [GHR_LENGTH-1:0] bpu_ghr;

    // retire oldest checkpoint
    logic                  cmt_vld;
    logic [CNT_W-1:0]      cmt_cnt;
    logic [PRED_WIDTH-1:0] cmt_hist;

    // mispredict redirect
    logic                  rdr_vld;
    logic [CKPT_IDX_W-1:0] rdr_ckpt_id;
    logic [CNT_W-1:0]      rdr_cnt;
    logic [PRED_WIDTH-1:0] rdr_hist;

    // full flush
    logic                  flush_vld;

    // status
    logic [CKPT_IDX_W:0]   ckpt_cnt;
    logic [GHR_LENGTH-1:0] cmt_ghr;

    modport master (
        output pred_vld, pred_cnt, pred_hist,
        output cmt_vld, cmt_cnt, cmt_hist,
        output rdr_vld, rdr_ckpt_id, rdr_cnt, rdr_hist,
        output flush_vld,
        input  pred_rdy, pred_ckpt_id, bpu_ghr, ckpt_cnt, cmt_ghr
    );

    modport slave (
        input  pred_vld, pred_cnt, pred_hist,
        input  cmt_vld, cmt_cnt, cmt_hist,
        input  rdr_vld, rdr_ckpt_id, rdr_cnt, rdr_hist,
        input  flush_vld,
        output pred_rdy, pred_ckpt_id, bpu_ghr, ckpt_cnt, cmt_ghr
    );
endinterface

// File: rtl/toy_bpu_ghr_ckpt.sv
// ---------------------------------------------------------------------------
// toy_bpu_ghr_ckpt
// Speculative global history register (GHR) with a circular checkpoint
// buffer. Every accepted prediction block saves the pre-update history in a
// checkpoint entry and shifts its predicted outcomes into bpu_ghr. A
// redirect rebuilds bpu_ghr from the saved checkpoint plus the corrected
// outcomes and frees every younger entry. Commits retire the oldest entry
// and advance the architectural history cmt_ghr; a flush copies cmt_ghr
// back into bpu_ghr and empties the buffer.
//
// Ports
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : toy_bpu_ghr_ckpt_if.slave
//          in  pred_vld/pred_cnt/pred_hist, cmt_vld/cmt_cnt/cmt_hist,
//              rdr_vld/rdr_ckpt_id/rdr_cnt/rdr_hist, flush_vld
//          out pred_rdy, pred_ckpt_id, bpu_ghr, ckpt_cnt, cmt_ghr
// All outputs are functions of registered state only.
// ---------------------------------------------------------------------------
module toy_bpu_ghr_ckpt #(
    parameter int GHR_LENGTH = 64,
    parameter int PRED_WIDTH = 2,
    parameter int CKPT_DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    toy_bpu_ghr_ckpt_if.slave bus
);
    localparam int CKPT_IDX_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W      = $clog2(PRED_WIDTH + 1);
    localparam int PTR_W      = CKPT_IDX_W + 1;

    // h << n with the n outcomes appended; x[0] is oldest so it ends up
    // highest of the inserted bits and x[n-1] lands in bit0. Counts above
    // PRED_WIDTH saturate.
    function automatic logic [GHR_LENGTH-1:0] ghr_shift(
        input logic [GHR_LENGTH-1:0] h,
        input logic [CNT_W-1:0]      n,
        input logic [PRED_WIDTH-1:0] x
    );
        logic [GHR_LENGTH-1:0] r;
        r = h;
        for (int i = 0; i < PRED_WIDTH; i++) begin
            if (i < int'(n))
                r = {r[GHR_LENGTH-2:0], x[i]};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [GHR_LENGTH-1:0] bpu_ghr_q;
    logic [GHR_LENGTH-1:0] cmt_ghr_q;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [GHR_LENGTH-1:0] ckpt_mem [CKPT_DEPTH];

    // ------------------------------------------------------------------
    // Occupancy and status
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]      occ;
    logic                  full;
    logic                  empty;
    logic [CKPT_IDX_W-1:0] rd_idx;
    logic [CKPT_IDX_W-1:0] wr_idx;

    // The wrap bit makes wr - rd the true occupancy, including full.
    assign occ    = wr_ptr - rd_ptr;
    assign full   = (occ == PTR_W'(CKPT_DEPTH));
    assign empty  = (occ == '0);
    assign rd_idx = rd_ptr[CKPT_IDX_W-1:0];
    assign wr_idx = wr_ptr[CKPT_IDX_W-1:0];

    assign bus.pred_rdy     = ~full;
    assign bus.pred_ckpt_id = wr_idx;
    assign bus.bpu_ghr      = bpu_ghr_q;
    assign bus.cmt_ghr      = cmt_ghr_q;
    assign bus.ckpt_cnt     = occ;

    // ------------------------------------------------------------------
    // Event decode; flush > redirect > prediction, commit runs alongside
    // anything but a flush.
    // ------------------------------------------------------------------
    logic                  pred_acc;
    logic                  cmt_ok;
    logic                  rdr_ok;
    logic [CKPT_IDX_W-1:0] rdr_off;
    logic [PTR_W-1:0]      rdr_wr;

    // A redirect on any id blocks the prediction in the same cycle, even
    // if the id turns out to be stale; upstream re-issues anyway.
    assign pred_acc = bus.pred_vld & ~full & ~bus.rdr_vld & ~bus.flush_vld;
    assign cmt_ok   = bus.cmt_vld & ~bus.flush_vld & ~empty;

    // Age of the redirected entry relative to the oldest one; it is live
    // only if that age is below the current occupancy. Uses the pre-commit
    // read pointer, so redirecting the entry being retired is fine.
    assign rdr_off  = bus.rdr_ckpt_id - rd_idx;
    assign rdr_ok   = bus.rdr_vld & ~bus.flush_vld &
                      ({1'b0, rdr_off} < occ);
    // Keep the redirected entry, drop everything younger.
    assign rdr_wr   = rd_ptr + {1'b0, rdr_off} + PTR_W'(1);

    logic [GHR_LENGTH-1:0] pred_ghr_nxt;
    logic [GHR_LENGTH-1:0] rdr_ghr_nxt;
    logic [GHR_LENGTH-1:0] cmt_ghr_nxt;

    assign pred_ghr_nxt = ghr_shift(bpu_ghr_q, bus.pred_cnt, bus.pred_hist);
    assign rdr_ghr_nxt  = ghr_shift(ckpt_mem[bus.rdr_ckpt_id], bus.rdr_cnt,
                                    bus.rdr_hist);
    assign cmt_ghr_nxt  = ghr_shift(cmt_ghr_q, bus.cmt_cnt, bus.cmt_hist);

    // ------------------------------------------------------------------
    // History registers and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bpu_ghr_q <= '0;
            cmt_ghr_q <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (bus.flush_vld) begin
            // Back to architectural history; everything in flight dies.
            bpu_ghr_q <= cmt_ghr_q;
            rd_ptr    <= wr_ptr;
        end else begin
            if (bus.rdr_vld) begin
                if (rdr_ok) begin
                    bpu_ghr_q <= rdr_ghr_nxt;
                    wr_ptr    <= rdr_wr;
                end
            end else if (pred_acc) begin
                bpu_ghr_q <= pred_ghr_nxt;
                wr_ptr    <= wr_ptr + PTR_W'(1);
            end

            if (cmt_ok) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                cmt_ghr_q <= cmt_ghr_nxt;
            end
        end
    end

    // Checkpoint storage holds the history seen before each block; it is
    // never reset since only entries between rd and wr are ever read.
    always_ff @(posedge clk) begin
        if (!rst && pred_acc)
            ckpt_mem[wr_idx] <= bpu_ghr_q;
    end

    // ------------------------------------------------------------------
    // Protocol checks (ignored by synthesis)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.cmt_vld && !bus.flush_vld && empty))
                else $warning("cmt_vld ignored: checkpoint buffer empty");
            assert (!(bus.rdr_vld && !bus.flush_vld && !rdr_ok))
                else $warning("rdr_vld ignored: id %0d not allocated",
                              bus.rdr_ckpt_id);
        end
    end

endmodule

// File: tb/tb_toy_bpu_ghr_ckpt.sv
// ---------------------------------------------------------------------------
// tb_toy_bpu_ghr_ckpt
// Directed scenarios with literal expectations followed by randomized
// traffic, all checked every cycle against a queue-based history model.
// Config: GHR_LENGTH=8, PRED_WIDTH=2, CKPT_DEPTH=4.
// ---------------------------------------------------------------------------
module tb_toy_bpu_ghr_ckpt;
    localparam int GL = 8;
    localparam int PW = 2;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    toy_bpu_ghr_ckpt_if #(.GHR_LENGTH(GL), .PRED_WIDTH(PW), .CKPT_DEPTH(CD)) bus ();

    toy_bpu_ghr_ckpt #(.GHR_LENGTH(GL), .PRED_WIDTH(PW), .CKPT_DEPTH(CD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of live checkpoints (id, saved history)
    // ------------------------------------------------------------------
    logic [GL-1:0] m_bpu, m_cmt;
    logic [GL-1:0] mq_ghr[$];
    int            mq_id[$];
    int            m_wr;

    // Insert n outcomes: old history moves up by n, outcome k weighs 2^(n-1-k).
    function automatic logic [GL-1:0] mshift(input logic [GL-1:0] h, input int n_in,
                                             input logic [PW-1:0] x);
        int n, low;
        n   = (n_in > PW) ? PW : n_in;
        low = 0;
        for (int k = 0; k < n; k++)
            if (x[k]) low = low + (1 << (n - 1 - k));
        return GL'((int'(h) << n) | low);
    endfunction

    task automatic model_step();
        int  n0, p;
        bit  com;
        if (rst) begin
            m_bpu = '0; m_cmt = '0; m_wr = 0;
            mq_ghr.delete(); mq_id.delete();
        end else if (bus.flush_vld) begin
            m_bpu = m_cmt;
            mq_ghr.delete(); mq_id.delete();
        end else begin
            n0  = mq_ghr.size();
            com = bus.cmt_vld && (n0 > 0);
            if (bus.rdr_vld) begin
                p = -1;
                for (int i = 0; i < n0; i++)
                    if (mq_id[i] == int'(bus.rdr_ckpt_id)) p = i;
                if (p >= 0) begin
                    m_bpu = mshift(mq_ghr[p], int'(bus.rdr_cnt), bus.rdr_hist);
                    while (mq_ghr.size() > p + 1) begin
                        void'(mq_ghr.pop_back());
                        void'(mq_id.pop_back());
                    end
                    m_wr = (p + 1 + mq_id[0]) % CD;
                end
            end else if (bus.pred_vld && n0 < CD) begin
                mq_ghr.push_back(m_bpu);
                mq_id.push_back(m_wr);
                m_bpu = mshift(m_bpu, int'(bus.pred_cnt), bus.pred_hist);
                m_wr  = (m_wr + 1) % CD;
            end
            if (com) begin
                void'(mq_ghr.pop_front());
                void'(mq_id.pop_front());
                m_cmt = mshift(m_cmt, int'(bus.cmt_cnt), bus.cmt_hist);
            end
        end
    endtask

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("bpu_ghr",      32'(bus.bpu_ghr),      32'(m_bpu));
            chk("cmt_ghr",      32'(bus.cmt_ghr),      32'(m_cmt));
            chk("ckpt_cnt",     32'(bus.ckpt_cnt),     32'(mq_ghr.size()));
            chk("pred_rdy",     32'(bus.pred_rdy),     32'(mq_ghr.size() < CD));
            chk("pred_ckpt_id", 32'(bus.pred_ckpt_id), 32'(m_wr));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        bus.pred_vld = 0; bus.pred_cnt = '0; bus.pred_hist = '0;
        bus.cmt_vld = 0;  bus.cmt_cnt = '0;  bus.cmt_hist = '0;
        bus.rdr_vld = 0;  bus.rdr_ckpt_id = '0; bus.rdr_cnt = '0; bus.rdr_hist = '0;
        bus.flush_vld = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_pred(input int c, input int h);
        bus.pred_vld = 1; bus.pred_cnt = 2'(c); bus.pred_hist = 2'(h);
    endtask

    task automatic do_cmt(input int c, input int h);
        bus.cmt_vld = 1; bus.cmt_cnt = 2'(c); bus.cmt_hist = 2'(h);
    endtask

    task automatic do_rdr(input int id, input int c, input int h);
        bus.rdr_vld = 1; bus.rdr_ckpt_id = 2'(id); bus.rdr_cnt = 2'(c); bus.rdr_hist = 2'(h);
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    initial begin
        int sz;
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        chk_en = 1;
        chk("rst_bpu", 32'(bus.bpu_ghr), 0);
        chk("rst_cnt", 32'(bus.ckpt_cnt), 0);
        chk("rst_rdy", 32'(bus.pred_rdy), 1);
        chk("rst_id",  32'(bus.pred_ckpt_id), 0);

        // first allocation
        do_pred(2, 2'b10);
        chk("a_id", 32'(bus.pred_ckpt_id), 0);
        tick(); idle();
        chk("a_bpu", 32'(bus.bpu_ghr), 32'h01);
        chk("a_cnt", 32'(bus.ckpt_cnt), 1);

        // fill to full, then a dropped prediction
        for (int i = 0; i < 3; i++) begin do_pred(1, 1); tick(); end
        idle();
        chk("full_cnt", 32'(bus.ckpt_cnt), 4);
        chk("full_rdy", 32'(bus.pred_rdy), 0);
        chk("full_bpu", 32'(bus.bpu_ghr), 32'h0F);
        do_pred(1, 1); tick(); idle();
        chk("drop_bpu", 32'(bus.bpu_ghr), 32'h0F);
        chk("drop_cnt", 32'(bus.ckpt_cnt), 4);

        // redirect to id0
        do_reset();
        do_pred(1, 1);
        chk("r_id0", 32'(bus.pred_ckpt_id), 0);
        tick();
        chk("r_bpu0", 32'(bus.bpu_ghr), 32'h01);
        do_pred(2, 2'b11);
        chk("r_id1", 32'(bus.pred_ckpt_id), 1);
        tick(); idle();
        chk("r_bpu1", 32'(bus.bpu_ghr), 32'h07);
        do_rdr(0, 1, 0); tick(); idle();
        chk("r_bpu", 32'(bus.bpu_ghr), 32'h00);
        chk("r_cnt", 32'(bus.ckpt_cnt), 1);
        chk("r_id",  32'(bus.pred_ckpt_id), 1);

        // commit then flush
        do_cmt(2, 2'b01); tick(); idle();
        chk("c_cmt", 32'(bus.cmt_ghr), 32'h02);
        chk("c_cnt", 32'(bus.ckpt_cnt), 0);
        bus.flush_vld = 1; tick(); idle();
        chk("f_bpu", 32'(bus.bpu_ghr), 32'h02);
        chk("f_cnt", 32'(bus.ckpt_cnt), 0);

        // all events together: only the flush takes effect
        do_pred(1, 1); tick(); idle();
        chk("x_pre", 32'(bus.bpu_ghr), 32'h05);
        do_pred(1, 1); do_rdr(1, 1, 1); do_cmt(1, 1); bus.flush_vld = 1;
        tick(); idle();
        chk("x_bpu", 32'(bus.bpu_ghr), 32'h02);
        chk("x_cmt", 32'(bus.cmt_ghr), 32'h02);
        chk("x_cnt", 32'(bus.ckpt_cnt), 0);
        chk("x_id",  32'(bus.pred_ckpt_id), 2);

        // id wrap through alloc/commit pairs, then commit on empty
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_pred(1, i & 1);
            chk("w_id", 32'(bus.pred_ckpt_id), 32'(i % 4));
            tick(); idle();
            chk("w_cnt1", 32'(bus.ckpt_cnt), 1);
            do_cmt(1, i & 1); tick(); idle();
            chk("w_cnt0", 32'(bus.ckpt_cnt), 0);
        end
        do_cmt(1, 1); tick(); idle();
        chk("e_cmt", 32'(bus.cmt_ghr), 32'h15);
        chk("e_bpu", 32'(bus.bpu_ghr), 32'h15);
        chk("e_cnt", 32'(bus.ckpt_cnt), 0);

        // randomized traffic; commits and redirects only target live entries
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            sz = mq_ghr.size();
            if ($urandom_range(0, 99) < 60)
                do_pred($urandom_range(0, 2), $urandom_range(0, 3));
            if (sz > 0 && $urandom_range(0, 99) < 35)
                do_cmt($urandom_range(0, 2), $urandom_range(0, 3));
            if (sz > 0 && $urandom_range(0, 99) < 10)
                do_rdr(mq_id[$urandom_range(0, sz - 1)], $urandom_range(0, 2),
                       $urandom_range(0, 3));
            if ($urandom_range(0, 99) < 3)
                bus.flush_vld = 1;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
